// File: rtl/storage_pkg.sv
// storage_pkg: constants and state encoding shared by the storage writer and
// storage reader blocks.
//   WIDTH    - number of display lines (bits in the storage vector)
//   IDX_W    - width of a returned line index
//   NONE_IDX - index reported when no line bit was set
//   state_t  - IDLE / SCAN / HOLD sequencing states
package storage_pkg;

    localparam int unsigned WIDTH    = 480;
    localparam int unsigned IDX_W    = 16;
    localparam logic [15:0] NONE_IDX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/storage_reader_if.sv
// storage_reader_if: request/result bundle between a requester and the
// storage reader.
//   start        - single-cycle decode request (requester -> reader)
//   storage_bits - one-hot line vector to decode (requester -> reader)
//   idx_ready    - requester accepts the held result (requester -> reader)
//   idx_out      - decoded line index (reader -> requester)
//   idx_valid    - result is being held (reader -> requester)
//   none_set     - captured vector had no bit set (reader -> requester)
//   multi_set    - captured vector had two or more bits set (reader -> requester)
//   busy         - reader is scanning or holding (reader -> requester)
interface storage_reader_if #(
    parameter int unsigned WIDTH = storage_pkg::WIDTH,
    parameter int unsigned IDX_W = storage_pkg::IDX_W
);

    logic             start;
    logic [WIDTH-1:0] storage_bits;
    logic             idx_ready;
    logic [IDX_W-1:0] idx_out;
    logic             idx_valid;
    logic             none_set;
    logic             multi_set;
    logic             busy;

    modport master (
        output start, storage_bits, idx_ready,
        input  idx_out, idx_valid, none_set, multi_set, busy
    );

    modport slave (
        input  start, storage_bits, idx_ready,
        output idx_out, idx_valid, none_set, multi_set, busy
    );

endinterface

// File: rtl/storage_reader.sv
// storage_reader: serially decodes a one-hot line vector into a line index.
// On start the vector is captured into a shadow register and examined one bit
// per clock, lowest index first. The first set bit gives the index; further
// set bits only mark the result as multi-hit. The result is held until the
// consumer accepts it.
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - storage_reader_if.slave (start, storage_bits, idx_ready in;
//         idx_out, idx_valid, none_set, multi_set, busy out)
module storage_reader #(
    parameter int unsigned WIDTH = storage_pkg::WIDTH,
    parameter int unsigned IDX_W = storage_pkg::IDX_W
) (
    input logic              clk,
    input logic              rst,
    storage_reader_if.slave  bus
);

    import storage_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] shadow;
    logic [IDX_W-1:0] cnt;
    logic [1:0]       hits;
    logic [IDX_W-1:0] idx_rec;
    logic             done;
    logic [IDX_W-1:0] idx_q;
    logic             none_q;
    logic             multi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.busy      = 1'b0;
        bus.idx_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                bus.busy = 1'b1;
                if (done) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                bus.busy      = 1'b1;
                bus.idx_valid = 1'b1;
                if (bus.idx_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The shadow register shifts right each scan cycle so the bit under
    // examination is always shadow[0]; cnt tracks its original position.
    // The edge after the last bit is examined publishes the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            cnt     <= '0;
            hits    <= '0;
            idx_rec <= '0;
            done    <= 1'b0;
            idx_q   <= '0;
            none_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        shadow  <= bus.storage_bits;
                        cnt     <= '0;
                        hits    <= '0;
                        idx_rec <= '0;
                        done    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!done) begin
                        if (shadow[0]) begin
                            if (hits == 2'd0) begin
                                idx_rec <= cnt;
                            end
                            if (hits != 2'd2) begin
                                hits <= hits + 2'd1;
                            end
                        end
                        shadow <= shadow >> 1;
                        if (cnt == LAST_IDX) begin
                            done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        idx_q   <= (hits == 2'd0) ? '1 : idx_rec;
                        none_q  <= (hits == 2'd0);
                        multi_q <= (hits == 2'd2);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.idx_out   = idx_q;
    assign bus.none_set  = none_q;
    assign bus.multi_set = multi_q;

endmodule
